pulse_gen: RTL and testbench
============================

# pulse_gen

Programmable pulse generator: the driving end of the event-counter interface. On a `Start` handshake it latches a pulse count and a mode bit, then emits exactly that many single-cycle pulses on `Pulse`. The pulses come either every enabled cycle (fast mode) or once every `DIV` enabled cycles (slow mode, the inverse of the counter's divide-by-4 slot). It drives the counter's event input in self-test and stimulus paths, and reports completion with a one-cycle `Done`.

## Interface
- `WIDTH`, 64: width of the pulse count and of the `Emitted` tally.
- `DIV`, 4: slow-mode period in enabled cycles; must be ≥2.

- `Clk`, in, 1: sole clock; all state updates on the rising edge.
- `Reset`, in, 1: reset, synchronous and active-high.
- `En`, in, 1: advance enable; low freezes the run.
- `Start`, in, 1: request a new run; honoured only in IDLE.
- `Slt`, in, 1: mode, sampled with `Start`; 0 = fast, 1 = slow (`DIV`).
- `Count`, in, `WIDTH`: number of pulses, sampled with `Start`.
- `Pulse`, out, 1: registered event pulse; each assertion lasts exactly one cycle.
- `Busy`, out, 1: high from the cycle after an accepted `Start` until completion.
- `Done`, out, 1: one-cycle completion strobe.
- `Emitted`, out, `WIDTH`: pulses emitted in the current or last run.

## Operation
- Internal state: FSM IDLE / RUN / DONE; `remaining` (`WIDTH` bits); `phase` (`$clog2(DIV)` bits); latched `mode`.
- Reset (at an edge with `Reset`=1, from any state, including mid-run):
  - FSM goes to IDLE.
  - `Pulse`, `Busy`, `Done`, `Emitted`, `remaining` and `phase` all become 0.
  - `Reset` has priority over every other input.
- IDLE:
  - `Start`=1 latches `Count` into `remaining` and `Slt` into `mode`, clears `Emitted` and `phase`, and sets `Busy`=1.
  - Next state is RUN if `Count`≠0, else DONE.
  - `En` is ignored in IDLE.
- RUN, evaluated at each edge in this order:
  - `remaining`==0: `Pulse`←0, `Busy`←0, `Done`←1, go to DONE. This check does not depend on `En`.
  - else `En`=0: `Pulse`←0; `phase`, `remaining` and `Emitted` hold.
  - else fast mode: `Pulse`←1, `remaining`←`remaining`−1, `Emitted`←`Emitted`+1.
  - else slow mode with `phase`==`DIV`−1: `phase`←0, then the same emit as fast mode.
  - else slow mode: `phase`←`phase`+1, `Pulse`←0.
- DONE:
  - `Done`←0, `Busy`←0, `Pulse`←0; go to IDLE. `Done` is therefore high for exactly one cycle.
  - `Start` is ignored in DONE.
  - `Count`==0 path: `Busy` is high for one cycle, then `Done` is high for one cycle.
- `Start` is ignored whenever `Busy` or `Done` is high; it is never queued.
- `Emitted` holds its final value after `Done` until the next accepted `Start` or `Reset`.
- Arithmetic:
  - `Emitted` never exceeds the latched `Count`, so it never wraps.
  - `Count` = 2^`WIDTH`−1 is legal.
  - `remaining` is decremented only when nonzero.

## Timing
Let the edge that accepts `Start` be edge 0, with `En` held at 1.
- Fast mode, N ≥ 1:
  - `Pulse`=1 after edges 1..N (N consecutive cycles).
  - After edge N+1: `Pulse`=0, `Busy`=0, `Done`=1.
  - After edge N+2: `Done`=0.
- Slow mode, N ≥ 1:
  - `Pulse`=1 only after edges `DIV`, 2·`DIV`, …, N·`DIV`.
  - `Done`=1 after edge N·`DIV`+1.
- Each enabled-low edge during RUN adds exactly one cycle of delay to all later events. The pulse count is unchanged.
- Latency from `Start` to first `Pulse`: 1 cycle (fast) or `DIV` cycles (slow).
- Minimum spacing between accepted `Start`s: N+3 cycles (fast), N·`DIV`+3 cycles (slow), 3 cycles (N=0).

## Test plan
- Reset then idle: `Pulse`, `Busy`, `Done` and `Emitted` are all 0 for 10 cycles, with `Start`=0 and `En` toggling.
- Fast run: `Start`, `Slt`=0, `Count`=5, `En`=1 → `Pulse` high after edges 1–5, `Done` only after edge 6, `Emitted`=5 and held.
- Slow run: `DIV`=4, `Slt`=1, `Count`=3 → pulses after edges 4, 8 and 12 only, `Done` after edge 13, `Emitted`=3.
- Pause: fast run with `Count`=4 and `En` dropped for 3 cycles after the second pulse → exactly 4 pulses, `Done` 3 cycles later than unpaused. Repeat in slow mode and check that `phase` holds during the pause.
- Edge cases:
  - `Count`=0 → no `Pulse`; `Busy` for 1 cycle, then `Done` for 1 cycle.
  - `Start` pulsed during RUN and during DONE → ignored; `Emitted` is not cleared.
- Reset mid-run: `Reset` asserted after the 2nd pulse of a `Count`=10 run → all outputs 0 at the next edge. A following `Start` with `Count`=1 yields one pulse and `Emitted`=1.

Source files
------------

// File: rtl/pulse_gen.sv
// ---------------------------------------------------------------------------
// pulse_gen -- programmable pulse generator
//
// A Start handshake in IDLE latches a pulse count and a mode bit. The block
// then emits exactly that many single-cycle pulses. In fast mode a pulse is
// emitted on every enabled cycle. In slow mode a pulse is emitted once every
// DIV enabled cycles. Completion is reported with a one-cycle Done strobe.
//
// Parameters
//   WIDTH : width of the pulse count and of the emitted tally
//   DIV   : slow-mode period in enabled cycles (must be >= 2)
//
// Ports
//   i_clk     : sole clock, rising edge
//   i_reset   : synchronous active-high reset; has priority over all inputs
//   i_en      : advance enable; low freezes a run in progress
//   i_start   : request a new run; honoured only in IDLE
//   i_slt     : mode, sampled with i_start (0 = fast, 1 = slow)
//   i_count   : number of pulses, sampled with i_start
//   o_pulse   : registered single-cycle event pulse
//   o_busy    : high from the cycle after an accepted start until completion
//   o_done    : one-cycle completion strobe
//   o_emitted : pulses emitted in the current or the last run
// ---------------------------------------------------------------------------
module pulse_gen #(
  parameter int WIDTH = 64,
  parameter int DIV   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_slt,
  input  logic [WIDTH-1:0] i_count,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_emitted
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] w_remaining_nxt;
  logic [PW-1:0]    r_phase;
  logic [PW-1:0]    w_phase_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [WIDTH-1:0] r_emitted;
  logic [WIDTH-1:0] w_emitted_nxt;

  // State register and datapath registers, reset to the idle condition
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_remaining <= {WIDTH{1'b0}};
      r_phase     <= {PW{1'b0}};
      r_mode      <= 1'b0;
      r_pulse     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_emitted   <= {WIDTH{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_phase     <= w_phase_nxt;
      r_mode      <= w_mode_nxt;
      r_pulse     <= w_pulse_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_emitted   <= w_emitted_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_count != {WIDTH{1'b0}}) ? S_RUN : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_remaining == {WIDTH{1'b0}}) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        // Arriving with busy still set means a zero-count run: spend one
        // more cycle here to raise the done strobe before returning to idle.
        if (r_busy) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_remaining_nxt = r_remaining;
    w_phase_nxt     = r_phase;
    w_mode_nxt      = r_mode;
    w_pulse_nxt     = 1'b0;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_emitted_nxt   = r_emitted;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_remaining_nxt = i_count;
          w_mode_nxt      = i_slt;
          w_phase_nxt     = {PW{1'b0}};
          w_emitted_nxt   = {WIDTH{1'b0}};
          w_busy_nxt      = 1'b1;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_RUN: begin
        // Completion is checked before the enable, so a run ends even while
        // the enable is low once every pulse has been emitted.
        if (r_remaining == {WIDTH{1'b0}}) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end else if (!i_en) begin
          w_pulse_nxt = 1'b0;
        end else if (!r_mode || (r_phase == PHASE_LAST)) begin
          w_phase_nxt     = {PW{1'b0}};
          w_pulse_nxt     = 1'b1;
          w_remaining_nxt = r_remaining - WIDTH'(1);
          w_emitted_nxt   = r_emitted + WIDTH'(1);
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      S_DONE: begin
        w_busy_nxt = 1'b0;
        if (r_busy) begin
          w_done_nxt = 1'b1;
        end else begin
          w_done_nxt = 1'b0;
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign o_pulse   = r_pulse;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_emitted = r_emitted;

endmodule

// File: tb/tb_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_pulse_gen -- self-checking bench for pulse_gen (WIDTH=64, DIV=4)
//
// Expected output vectors are derived from the documented timing, pushed to
// a scoreboard queue as each edge is stimulated, and compared against the
// observed vectors one cycle at a time by each scenario task.
// ---------------------------------------------------------------------------
module tb_pulse_gen;

  localparam int WIDTH = 64;
  localparam int DIV   = 4;

  typedef struct packed {
    logic        pulse;
    logic        busy;
    logic        done;
    logic [63:0] emitted;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             start;
  logic             slt;
  logic [WIDTH-1:0] count;
  logic             pulse;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] emitted;

  int checks   = 0;
  int failures = 0;

  vec_t exp_q[$];
  vec_t obs_q[$];

  pulse_gen #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_en      (en),
    .i_start   (start),
    .i_slt     (slt),
    .i_count   (count),
    .o_pulse   (pulse),
    .o_busy    (busy),
    .o_done    (done),
    .o_emitted (emitted)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and record the outputs shortly after it.
  task automatic tick();
    @(posedge clk);
    #1;
    obs_q.push_back({pulse, busy, done, emitted});
  endtask

  // Drive one run from the accepting edge onward, pushing the expected
  // vector for every edge. Enable is low for pause_len edges starting at
  // edge pause_at; a stray start is offered at edges glitch_a and glitch_b.
  task automatic run_scenario(input logic [63:0] n, input logic slow,
                              input int pause_at, input int pause_len,
                              input int glitch_a, input int glitch_b,
                              input int limit);
    logic [63:0] p;
    logic [63:0] total;
    logic [63:0] t;
    logic        finished;
    logic        en_k;
    int          post;
    int          k;
    vec_t        e;
    p        = slow ? 64'(DIV) : 64'd1;
    total    = n * p;
    t        = 64'd0;
    finished = 1'b0;
    post     = 0;
    // Edge 0: start accepted
    start = 1'b1;
    slt   = slow;
    count = n;
    en    = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 64'd0});
    tick();
    start = 1'b0;
    k = 1;
    while (k <= limit && post < 3) begin
      en_k = !(pause_len > 0 && k >= pause_at && k < pause_at + pause_len);
      if (finished) begin
        e = {1'b0, 1'b0, 1'b0, n};
        post++;
      end else if (t == total) begin
        e = {1'b0, 1'b0, 1'b1, n};
        finished = 1'b1;
      end else if (en_k) begin
        t++;
        e = {(t % p) == 64'd0, 1'b1, 1'b0, t / p};
      end else begin
        e = {1'b0, 1'b1, 1'b0, t / p};
      end
      en    = en_k;
      start = (k == glitch_a) || (k == glitch_b);
      if (start) begin
        count = 64'd7;
        slt   = ~slow;
      end
      exp_q.push_back(e);
      tick();
      start = 1'b0;
      k++;
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    vec_t e;
    vec_t o;
    int   c;
    reset = 1'b1;
    start = 1'b1;
    en    = 1'b1;
    slt   = 1'b0;
    count = 64'd9;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en = i[0];
      exp_q.push_back('0);
      tick();
    end
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset cyc=%0d got p=%b b=%b d=%b em=%0d exp p=%b b=%b d=%b em=%0d",
                 c, o.pulse, o.busy, o.done, o.emitted, e.pulse, e.busy, e.done, e.emitted);
      end
      c++;
    end
  endtask

  task automatic test_fast();
    vec_t e;
    vec_t o;
    int   c;
    run_scenario(64'd5, 1'b0, 0, 0, -1, -1, 40);
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL fast cyc=%0d got p=%b b=%b d=%b em=%0d exp p=%b b=%b d=%b em=%0d",
                 c, o.pulse, o.busy, o.done, o.emitted, e.pulse, e.busy, e.done, e.emitted);
      end
      c++;
    end
  endtask

  task automatic test_slow();
    vec_t e;
    vec_t o;
    int   c;
    run_scenario(64'd3, 1'b1, 0, 0, -1, -1, 40);
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL slow cyc=%0d got p=%b b=%b d=%b em=%0d exp p=%b b=%b d=%b em=%0d",
                 c, o.pulse, o.busy, o.done, o.emitted, e.pulse, e.busy, e.done, e.emitted);
      end
      c++;
    end
  endtask

  task automatic test_pause();
    vec_t e;
    vec_t o;
    int   c;
    // Fast: pause after the second pulse; slow: pause mid-period.
    run_scenario(64'd4, 1'b0, 3, 3, -1, -1, 40);
    run_scenario(64'd3, 1'b1, 6, 3, -1, -1, 40);
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL pause cyc=%0d got p=%b b=%b d=%b em=%0d exp p=%b b=%b d=%b em=%0d",
                 c, o.pulse, o.busy, o.done, o.emitted, e.pulse, e.busy, e.done, e.emitted);
      end
      c++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t e;
    vec_t o;
    int   c;
    // Zero-count run followed at once by a two-pulse run.
    run_scenario(64'd0, 1'b0, 0, 0, -1, -1, 40);
    run_scenario(64'd2, 1'b0, 0, 0, -1, -1, 40);
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got p=%b b=%b d=%b em=%0d exp p=%b b=%b d=%b em=%0d",
                 c, o.pulse, o.busy, o.done, o.emitted, e.pulse, e.busy, e.done, e.emitted);
      end
      c++;
    end
  endtask

  task automatic test_ignore_start();
    vec_t e;
    vec_t o;
    int   c;
    // Start offered during RUN (edge 2) and while in DONE (edge 5).
    run_scenario(64'd3, 1'b0, 0, 0, 2, 5, 40);
    run_scenario(64'd2, 1'b1, 0, 0, 3, 10, 40);
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL ignore_start cyc=%0d got p=%b b=%b d=%b em=%0d exp p=%b b=%b d=%b em=%0d",
                 c, o.pulse, o.busy, o.done, o.emitted, e.pulse, e.busy, e.done, e.emitted);
      end
      c++;
    end
  endtask

  task automatic test_max_and_midrun_reset();
    vec_t e;
    vec_t o;
    int   c;
    // Largest legal count: a few pulses, then reset with start also high.
    run_scenario({64{1'b1}}, 1'b0, 0, 0, -1, -1, 6);
    reset = 1'b1;
    start = 1'b1;
    exp_q.push_back('0);
    tick();
    reset = 1'b0;
    start = 1'b0;
    // Count=10 run interrupted by reset right after its second pulse.
    run_scenario(64'd10, 1'b0, 0, 0, -1, -1, 2);
    reset = 1'b1;
    exp_q.push_back('0);
    tick();
    reset = 1'b0;
    run_scenario(64'd1, 1'b0, 0, 0, -1, -1, 40);
    c = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL max_midrun_reset cyc=%0d got p=%b b=%b d=%b em=%0d exp p=%b b=%b d=%b em=%0d",
                 c, o.pulse, o.busy, o.done, o.emitted, e.pulse, e.busy, e.done, e.emitted);
      end
      c++;
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    start = 1'b0;
    slt   = 1'b0;
    count = 64'd0;
    #1;
    test_reset();
    test_fast();
    test_slow();
    test_pause();
    test_back_to_back();
    test_ignore_start();
    test_max_and_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
